// File: rtl/router_in_buffer.sv
// Per-input-port ingress FIFO feeding one client slot of the round-robin arbiter.
// Optional same-cycle bypass of an empty buffer: define ROUTER_IN_BUFFER_BYPASS_EN.
module router_in_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AFULL_THRESH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic push;
    logic pop;
    logic bypass_take;

    assign in_ready      = (count_q != CNT_W'(DEPTH));
    assign almost_full   = (count_q >= CNT_W'(AFULL_THRESH));
    assign count         = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    // Head presentation; the bypass lets an empty buffer forward the incoming flit.
`ifdef ROUTER_IN_BUFFER_BYPASS_EN
    always_comb begin
        out_valid   = (count_q != '0) || in_valid;
        out_data    = (count_q == '0) ? in_data : mem_q[rd_ptr_q];
        bypass_take = (count_q == '0) && in_valid && out_pop;
    end
`else
    always_comb begin
        out_valid   = (count_q != '0);
        out_data    = mem_q[rd_ptr_q];
        bypass_take = 1'b0;
    end
`endif

    always_comb begin
        push        = in_valid && in_ready;
        pop         = out_pop && out_valid;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (in_valid && !in_ready);
        underflow_d = underflow_q | (out_pop && !out_valid);

        // A bypassed-and-consumed flit never touches storage.
        if (push && !bypass_take) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !bypass_take) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_router_in_buffer.sv
// Scoreboard bench for router_in_buffer: directed test-plan scenarios plus random traffic
// against a queue-based FIFO model; honours ROUTER_IN_BUFFER_BYPASS_EN when defined.
module tb_router_in_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AFULL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_pop = 1'b0;
    logic [2:0]    count;
    logic          almost_full;
    logic          overflow_err;
    logic          underflow_err;

    router_in_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(AFULL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_pop(out_pop),
        .count(count), .almost_full(almost_full),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: flits in arrival order, occupancy, sticky flags.
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    bit            m_ovf = 0;
    bit            m_unf = 0;

`ifdef ROUTER_IN_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, called just after a rising edge.
    task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit pop);
        bit push_ok, byp, pop_ok;
        int nxt;
        in_valid = iv;
        in_data  = d;
        out_pop  = pop;
        push_ok  = iv && (m_count != DEPTH);
        byp      = BYP && (m_count == 0) && iv;
        pop_ok   = pop && ((m_count != 0) || byp);
        if (push_ok) exp_q.push_back(d);
        nxt = m_count + int'(push_ok) - int'(pop_ok);
        @(posedge clk);
        #1;
        m_count = nxt;
        m_ovf   = m_ovf | (iv && !push_ok);
        m_unf   = m_unf | (pop && !pop_ok);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    // Monitor: compares registered state and the head against the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            bit ev;
            ev = (m_count != 0) || (BYP && in_valid && m_count == 0);
            chk("count", 64'(count), 64'(m_count));
            chk("in_ready", 64'(in_ready), 64'(m_count != DEPTH));
            chk("almost_full", 64'(almost_full), 64'(m_count >= AFULL));
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            chk("underflow_err", 64'(underflow_err), 64'(m_unf));
            chk("out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 64'(0), 64'(1));
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_q[0]));
                    if (out_pop) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_af", 64'(almost_full), 64'(0));
        chk("rst_errs", 64'({overflow_err, underflow_err}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic push then pop
        cycle(1, 32'hA5A5_0001, 0);
        chk("basic_count", 64'(count), 64'(1));
        chk("basic_valid", 64'(out_valid), 64'(1));
        chk("basic_data", 64'(out_data), 64'h0000_0000_A5A5_0001);
        cycle(0, 0, 1);
        chk("basic_pop_count", 64'(count), 64'(0));

        // Fill to full, overflow, drain
        for (int i = 0; i < 4; i++) begin
            cycle(1, DW'(32'h10 + i), 0);
            if (i == 1) chk("fill_af_low", 64'(almost_full), 64'(0));
            if (i == 2) chk("fill_af_high", 64'(almost_full), 64'(1));
        end
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_count", 64'(count), 64'(4));
        cycle(1, 32'h14, 0);
        chk("ovf_flag", 64'(overflow_err), 64'(1));
        chk("ovf_count", 64'(count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 64'(out_data), 64'(32'h10 + i));
            cycle(0, 0, 1);
        end
        chk("drain_count", 64'(count), 64'(0));

        // Mid-operation asynchronous reset with three flits stored
        for (int i = 0; i < 3; i++) cycle(1, DW'(32'h20 + i), 0);
        in_valid = 1'b0; out_pop = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_errs", 64'({overflow_err, underflow_err}), 64'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wrap-around with occupancy held at 2
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        for (int i = 2; i < 12; i++) begin
            cycle(1, DW'(i), 1);
            chk("wrap_count", 64'(count), 64'(2));
        end
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("wrap_errs", 64'({overflow_err, underflow_err}), 64'(0));

        // Simultaneous push and pop at count 1
        cycle(1, 32'h30, 0);
        cycle(1, 32'h31, 1);
        chk("simul_count", 64'(count), 64'(1));
        chk("simul_head", 64'(out_data), 64'h31);
        cycle(0, 0, 1);

        // Underflow on empty
        cycle(0, 0, 1);
        chk("unf_flag", 64'(underflow_err), 64'(1));
        chk("unf_count", 64'(count), 64'(0));

        // Bypass probe on empty buffer (monitor checks same-cycle out_valid)
        cycle(1, 32'hBEEF, 1);
        chk("byp_count", 64'(count), 64'(BYP ? 0 : 1));
        cycle(0, 0, 1);

        // Random traffic from a clean state
        in_valid = 1'b0; out_pop = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit iv, pp;
            iv = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 50) && ((m_count != 0) || (BYP && iv));
            cycle(iv, $urandom, pp);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, m_count != 0);
        chk("final_count", 64'(count), 64'(0));
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_in_buffer.md
Name: router_in_buffer

Overview:
- Per-input-port ingress FIFO for the router.
- Accepts flits from the link side with a valid/ready handshake and stores them in a circular buffer.
- Presents the head flit to the round-robin arbiter as one bit of its valid_candidate vector.
- Pops the head when the matching bit of the arbiter's one-hot winner_dec_id is asserted; one instance per arbiter client.

Parameters:
- DEPTH, 4, number of flit entries; power of 2, >= 2.
- DATA_WIDTH, 32, flit width in bits.
- AFULL_THRESH, 3, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream flit valid.
- in_data  input  DATA_WIDTH  upstream flit.
- in_ready  output  1  buffer can accept a flit this cycle.
- out_valid  output  1  head flit valid; drives arbiter valid_candidate[i].
- out_data  output  DATA_WIDTH  head flit.
- out_pop  input  1  arbiter winner_dec_id[i]; consume head.
- count  output  $clog2(DEPTH+1)  current occupancy.
- almost_full  output  1  count >= AFULL_THRESH.
- overflow_err  output  1  sticky: push attempted while full.
- underflow_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, out_data = 0, in_ready = 1, almost_full = 0, both error flags = 0. Asserting rst_n mid-operation discards all stored flits immediately.
- Storage: DEPTH x DATA_WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with natural overflow.
- Fullness: in_ready = (count != DEPTH). It depends only on registered count; there is no combinational path from out_pop or in_valid.
- Push: fires when in_valid && in_ready. It writes mem[wr_ptr] and advances wr_ptr at the next edge.
- Head: out_valid = (count != 0) and out_data = mem[rd_ptr]. Both are registered-state driven, with first-word-fall-through one cycle after the push edge.
- Pop: fires when out_pop && out_valid. It advances rd_ptr at the next edge.
- Occupancy update:
  - count +1 on push only.
  - count -1 on pop only.
  - count unchanged on simultaneous push and pop.
  - Simultaneous push and pop is legal at any occupancy 1..DEPTH-1, and at full only if in_ready (never, since full means in_ready = 0).
- Full: an in_valid while !in_ready drops the flit, leaves state unchanged and sets overflow_err. A pop in the same cycle does not rescue the dropped flit.
- Empty: out_pop while !out_valid is ignored and sets underflow_err. This can occur legally only if the arbiter is mis-wired, because the arbiter never grants a non-candidate.
- Error flags: sticky; cleared only by reset.
- Arbiter coupling: the arbiter is combinational from valid_candidate to winner_dec_id. out_pop may therefore arrive in the same cycle out_valid rises; this is legal.
- almost_full: a combinational compare on registered count, intended for upstream credit throttling.

Optional Feature:
- Macro: ROUTER_IN_BUFFER_BYPASS_EN.
- Defined, out_valid: when count == 0 and in_valid is asserted, out_valid = 1 and out_data = in_data in the same cycle (combinational bypass).
- Defined, bypass with pop: if out_pop is also asserted that cycle, the flit is consumed without being written; pointers and count are unchanged.
- Defined, bypass without pop: the flit is written normally and appears as the registered head next cycle.
- Defined, in_ready: unchanged.
- Not defined: no bypass. A flit pushed into an empty buffer is first visible the cycle after the push edge (latency 1).

Test Plan:
- Reset/basic: reset, push 0xA5A5_0001 at cycle 1 -> out_valid = 1, out_data = 0xA5A5_0001, count = 1 at cycle 2. Pop at cycle 2 -> count = 0 at cycle 3.
- Fill to full: push 4 flits 0x10..0x13 with no pops -> almost_full = 1 after the 3rd; in_ready = 0 and count = 4 after the 4th. A 5th push of 0x14 is dropped, overflow_err = 1. Drain yields 0x10, 0x11, 0x12, 0x13 in order.
- Wrap-around: 10 push/pop pairs with occupancy held at 2 and data 0..9 -> pops return 0..9 in order, count stays 2, no error flags.
- Simultaneous push+pop at count = 1 -> count stays 1; next head is the new flit.
- Underflow and reset mid-op:
  - Empty buffer, out_pop = 1 -> underflow_err = 1, count = 0.
  - With 3 flits stored, drop rst_n mid-cycle -> count = 0, out_valid = 0, errors = 0 immediately.
- Bypass (macro defined), empty buffer: in_valid = 1, in_data = 0xBEEF, out_pop = 1 in the same cycle -> out_valid = 1 and out_data = 0xBEEF that cycle; count = 0 afterwards. With the macro undefined -> out_valid = 0 that cycle, count = 1 next cycle.
